// File: rtl/alarm_pkg.sv
// Shared types for the alarm path: BCD digit, packed hh:mm:ss time and the alarm FSM states.
package alarm_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef struct packed {
        bcd_digit_t hourMsb;
        bcd_digit_t hourLsb;
        bcd_digit_t minMsb;
        bcd_digit_t minLsb;
        bcd_digit_t secMsb;
        bcd_digit_t secLsb;
    } bcd_time_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } alarm_state_t;

    function automatic int maxInt(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/alarm_trigger_if.sv
// Bundle of the alarm trigger's user controls, time/alarm digits and annunciator outputs.
interface alarm_trigger_if;
    import alarm_pkg::*;

    logic       tick_1hz;
    logic       alarm_en;
    logic       stop;
    logic       snooze;

    bcd_digit_t cur_hour_msb;
    bcd_digit_t cur_hour_lsb;
    bcd_digit_t cur_min_msb;
    bcd_digit_t cur_min_lsb;
    bcd_digit_t cur_sec_msb;
    bcd_digit_t cur_sec_lsb;

    bcd_digit_t alm_hour_msb;
    bcd_digit_t alm_hour_lsb;
    bcd_digit_t alm_min_msb;
    bcd_digit_t alm_min_lsb;
    bcd_digit_t alm_sec_msb;
    bcd_digit_t alm_sec_lsb;

    logic       buzzer;
    logic       ringing;
    logic       snoozing;

    modport master (
        output tick_1hz, alarm_en, stop, snooze,
        output cur_hour_msb, cur_hour_lsb, cur_min_msb, cur_min_lsb, cur_sec_msb, cur_sec_lsb,
        output alm_hour_msb, alm_hour_lsb, alm_min_msb, alm_min_lsb, alm_sec_msb, alm_sec_lsb,
        input  buzzer, ringing, snoozing
    );

    modport slave (
        input  tick_1hz, alarm_en, stop, snooze,
        input  cur_hour_msb, cur_hour_lsb, cur_min_msb, cur_min_lsb, cur_sec_msb, cur_sec_lsb,
        input  alm_hour_msb, alm_hour_lsb, alm_min_msb, alm_min_lsb, alm_sec_msb, alm_sec_lsb,
        output buzzer, ringing, snoozing
    );

endinterface

// File: rtl/bcd_time_match.sv
// Combinational hh:mm:ss equality on raw nibbles (no BCD validity check).
// Shared with the display blink logic, so it stays free of any alarm state.
module bcd_time_match
    import alarm_pkg::*;
(
    input  bcd_time_t i_timeA,
    input  bcd_time_t i_timeB,
    output logic      o_match
);

    logic [5:0] w_digitEq;

    always_comb begin
        w_digitEq    = '0;
        w_digitEq[5] = (i_timeA.hourMsb == i_timeB.hourMsb);
        w_digitEq[4] = (i_timeA.hourLsb == i_timeB.hourLsb);
        w_digitEq[3] = (i_timeA.minMsb  == i_timeB.minMsb);
        w_digitEq[2] = (i_timeA.minLsb  == i_timeB.minLsb);
        w_digitEq[1] = (i_timeA.secMsb  == i_timeB.secMsb);
        w_digitEq[0] = (i_timeA.secLsb  == i_timeB.secLsb);
    end

    assign o_match = &w_digitEq;

endmodule

// File: rtl/alarm_trigger.sv
// Alarm trigger: rings on the rising edge of time==alarm, handles stop/snooze/timeout.
// Build option ALARM_TRIGGER_BEEP_EN: buzzer beeps at 0.5 Hz instead of a steady tone.
module alarm_trigger
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = 60,
    parameter int SNOOZE_S       = 300
)
(
    input  logic            clk,
    input  logic            reset,
    alarm_trigger_if.slave  bus
);

    localparam int               CNT_W     = $clog2(maxInt(RING_TIMEOUT_S, SNOOZE_S) + 1);
    localparam logic [CNT_W-1:0] RING_LOAD = CNT_W'(RING_TIMEOUT_S);
    localparam logic [CNT_W-1:0] SNZ_LOAD  = CNT_W'(SNOOZE_S);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    bcd_time_t        w_curTime;
    bcd_time_t        w_almTime;
    logic             w_match;
    logic             w_trigger;

    alarm_state_t     r_state;
    alarm_state_t     w_nextState;
    logic [CNT_W-1:0] r_ringCnt;
    logic [CNT_W-1:0] w_nextRingCnt;
    logic [CNT_W-1:0] r_snzCnt;
    logic [CNT_W-1:0] w_nextSnzCnt;
    logic             r_matchQ;
    logic             r_buzzer;
    logic             w_nextBuzzer;
    logic             r_ringing;
    logic             r_snoozing;

    assign w_curTime = {bus.cur_hour_msb, bus.cur_hour_lsb, bus.cur_min_msb,
                        bus.cur_min_lsb,  bus.cur_sec_msb,  bus.cur_sec_lsb};
    assign w_almTime = {bus.alm_hour_msb, bus.alm_hour_lsb, bus.alm_min_msb,
                        bus.alm_min_lsb,  bus.alm_sec_msb,  bus.alm_sec_lsb};

    bcd_time_match u_match (
        .i_timeA (w_curTime),
        .i_timeB (w_almTime),
        .o_match (w_match)
    );

    // Only the first cycle of a match rings; a held match must not re-arm.
    assign w_trigger = w_match & ~r_matchQ & bus.alarm_en;

    always_comb begin
        w_nextState   = r_state;
        w_nextRingCnt = r_ringCnt;
        w_nextSnzCnt  = r_snzCnt;

        if (!bus.alarm_en) begin
            w_nextState = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_trigger) begin
                        w_nextState   = RINGING;
                        w_nextRingCnt = RING_LOAD;
                    end
                end
                RINGING: begin
                    if (bus.stop) begin
                        w_nextState = IDLE;
                    end else if (bus.snooze) begin
                        w_nextState  = SNOOZE;
                        w_nextSnzCnt = SNZ_LOAD;
                    end else if (bus.tick_1hz) begin
                        if (r_ringCnt == CNT_ONE) begin
                            w_nextState = IDLE;
                        end else begin
                            w_nextRingCnt = r_ringCnt - CNT_ONE;
                        end
                    end
                end
                SNOOZE: begin
                    if (bus.stop) begin
                        w_nextState = IDLE;
                    end else if (bus.tick_1hz) begin
                        if (r_snzCnt == CNT_ONE) begin
                            w_nextState   = RINGING;
                            w_nextRingCnt = RING_LOAD;
                        end else begin
                            w_nextSnzCnt = r_snzCnt - CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

`ifdef ALARM_TRIGGER_BEEP_EN
    // Silent on entry to RINGING, then flips once per second while it stays there.
    always_comb begin
        w_nextBuzzer = 1'b0;
        if ((w_nextState == RINGING) && (r_state == RINGING)) begin
            w_nextBuzzer = bus.tick_1hz ? ~r_buzzer : r_buzzer;
        end
    end
`else
    assign w_nextBuzzer = (w_nextState == RINGING);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ringCnt  <= '0;
            r_snzCnt   <= '0;
            r_matchQ   <= 1'b0;
            r_buzzer   <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_ringCnt  <= w_nextRingCnt;
            r_snzCnt   <= w_nextSnzCnt;
            r_matchQ   <= w_match;
            r_buzzer   <= w_nextBuzzer;
            r_ringing  <= (w_nextState == RINGING);
            r_snoozing <= (w_nextState == SNOOZE);
        end
    end

    assign bus.buzzer   = r_buzzer;
    assign bus.ringing  = r_ringing;
    assign bus.snoozing = r_snoozing;

endmodule
